// File: rtl/exu_pkg.sv
// Shared constants for the execute-unit ALU control stage: select codes,
// main-control aluop classes and the control FSM state encoding.
package exu_pkg;

    localparam int unsigned ALU_CODE_W = 5;

    localparam logic [ALU_CODE_W-1:0] ALU_AND     = 5'h00;
    localparam logic [ALU_CODE_W-1:0] ALU_OR      = 5'h01;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD     = 5'h02;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR     = 5'h03;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL     = 5'h04;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL     = 5'h05;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB     = 5'h06;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA     = 5'h07;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT     = 5'h08;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU    = 5'h09;
    localparam logic [ALU_CODE_W-1:0] ALU_MD_BASE = 5'h10;
    localparam logic [ALU_CODE_W-1:0] ALU_ILLEGAL = 5'h1F;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/exu_decode.sv
// Combinational ALU-select decode from {aluop, funct3, funct7_5, funct7_0}.
// M-extension decode is present only when EXU_MULDIV_EN is defined.
module exu_decode
    import exu_pkg::*;
#(
    parameter int unsigned SEL_W = 5
) (
    input  logic [1:0]       i_aluop,
    input  logic [2:0]       i_funct3,
    input  logic             i_funct7_5,
    input  logic             i_funct7_0,
    output logic [SEL_W-1:0] o_alu_sel,
    output logic             o_illegal
`ifdef EXU_MULDIV_EN
    ,
    output logic             o_is_md
`endif
);

    logic [ALU_CODE_W-1:0] w_code;
    logic                  w_illegal;
    logic                  w_is_md;

    always_comb begin
        w_code    = ALU_ILLEGAL;
        w_illegal = 1'b1;
        w_is_md   = 1'b0;
        if (i_aluop[0]) begin
            w_code    = ALU_SUB;
            w_illegal = 1'b0;
        end else if (i_aluop == ALUOP_ADD) begin
            w_code    = ALU_ADD;
            w_illegal = 1'b0;
        end else if (i_funct7_0) begin
`ifdef EXU_MULDIV_EN
            w_code    = ALU_MD_BASE | ALU_CODE_W'(i_funct3);
            w_illegal = 1'b0;
            w_is_md   = 1'b1;
`endif
        end else begin
            w_illegal = 1'b0;
            case ({i_funct7_5, i_funct3})
                4'b0000: w_code = ALU_ADD;
                4'b1000: w_code = ALU_SUB;
                4'b0111: w_code = ALU_AND;
                4'b0110: w_code = ALU_OR;
                4'b0100: w_code = ALU_XOR;
                4'b0001: w_code = ALU_SLL;
                4'b0101: w_code = ALU_SRL;
                4'b1101: w_code = ALU_SRA;
                4'b0010: w_code = ALU_SLT;
                4'b0011: w_code = ALU_SLTU;
                default: begin
                    w_code    = ALU_ILLEGAL;
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    // Illegal ops drive every select bit high regardless of SEL_W.
    assign o_alu_sel = w_illegal ? {SEL_W{1'b1}} : SEL_W'(w_code);
    assign o_illegal = w_illegal;
`ifdef EXU_MULDIV_EN
    assign o_is_md = w_is_md;
`else
    logic w_unused_md;
    assign w_unused_md = w_is_md;
`endif

endmodule

// File: rtl/exu_ctrl.sv
// Registered, handshaked ALU-control stage. Iterative mul/div sequencing
// (RUN state, cycle counter, md_start/md_busy) exists only with EXU_MULDIV_EN.
module exu_ctrl
    import exu_pkg::*;
#(
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             funct7_0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] alu_sel,
    output logic             illegal,
    output logic             md_start,
    output logic             md_busy
);

    localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    state_t           r_state;
    state_t           w_next;
    state_t           w_accept_tgt;
    logic             w_accept;
    logic [SEL_W-1:0] w_dec_sel;
    logic             w_dec_ill;
    logic             w_dec_md;

`ifdef EXU_MULDIV_EN
    logic [CNT_W-1:0] r_cnt;

    exu_decode #(.SEL_W(SEL_W)) u_decode (
        .i_aluop    (aluop),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .i_funct7_0 (funct7_0),
        .o_alu_sel  (w_dec_sel),
        .o_illegal  (w_dec_ill),
        .o_is_md    (w_dec_md)
    );
    assign w_accept_tgt = w_dec_md ? ST_RUN : ST_OUT;
`else
    exu_decode #(.SEL_W(SEL_W)) u_decode (
        .i_aluop    (aluop),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .i_funct7_0 (funct7_0),
        .o_alu_sel  (w_dec_sel),
        .o_illegal  (w_dec_ill)
    );
    assign w_dec_md     = 1'b0;
    assign w_accept_tgt = ST_OUT;
`endif

    // Ready depends on downstream only while holding a result.
    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_next = w_accept_tgt;
                end
                ST_OUT: begin
                    if (w_accept)       w_next = w_accept_tgt;
                    else if (out_ready) w_next = ST_IDLE;
                end
`ifdef EXU_MULDIV_EN
                ST_RUN: begin
                    if (r_cnt == '0) w_next = ST_OUT;
                end
`endif
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Select and illegal flag change only on accept so they hold under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_sel   <= '0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= (w_next == ST_OUT);
            if (w_accept) begin
                alu_sel <= w_dec_sel;
                illegal <= w_dec_ill;
            end
        end
    end

`ifdef EXU_MULDIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_start <= 1'b0;
            md_busy  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            md_start <= w_accept && w_dec_md;
            md_busy  <= (w_next == ST_RUN);
            if (flush) begin
                r_cnt <= '0;
            end else if (w_accept && w_dec_md) begin
                r_cnt <= CNT_W'(MD_CYCLES - 1);
            end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
`else
    assign md_start = 1'b0;
    assign md_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_exu_ctrl.sv
// Scoreboard bench for exu_ctrl: directed decode vectors, mul/div timing,
// backpressure, flush and reset; honours EXU_MULDIV_EN.
module tb_exu_ctrl;

    localparam int unsigned SEL_W  = 5;
    localparam int unsigned MD_CYC = 4;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             ill;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             funct7_0;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] alu_sel;
    logic             illegal;
    logic             md_start;
    logic             md_busy;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [3:0] CODES [10] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                                          4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};
    localparam logic [4:0] SELS  [10] = '{5'h02, 5'h06, 5'h00, 5'h01, 5'h03,
                                          5'h04, 5'h05, 5'h07, 5'h08, 5'h09};

    exu_ctrl #(.SEL_W(SEL_W), .MD_CYCLES(MD_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .funct7_0  (funct7_0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_sel   (alu_sel),
        .illegal   (illegal),
        .md_start  (md_start),
        .md_busy   (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed output transfer pops one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got sel 0x%0h with empty scoreboard at %0t", alu_sel, $time);
            end else begin
                e = q.pop_front();
                chk("out_sel", 32'(alu_sel), 32'(e.sel));
                chk("out_illegal", 32'(illegal), 32'(e.ill));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic [4:0] esel, input logic eill,
                         input bit push);
        int t;
        t        = 0;
        aluop    = op;
        funct3   = f3;
        funct7_5 = f75;
        funct7_0 = f70;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 at %0t", $time);
        end else if (push) begin
            q.push_back(exp_t'{sel: esel, ill: eill});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        aluop     = 2'b00;
        funct3    = 3'b000;
        funct7_5  = 1'b0;
        funct7_0  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu_sel", 32'(alu_sel), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_md_busy", 32'(md_busy), 0);
        chk("rst_md_start", 32'(md_start), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // R-type sweep, back-to-back
        for (int i = 0; i < 10; i++) begin
            logic [3:0] c;
            c = CODES[i];
            issue(2'b10, c[2:0], c[3], 1'b0, SELS[i], 1'b0, 1'b1);
        end
        issue(2'b10, 3'b010, 1'b1, 1'b0, 5'h1F, 1'b1, 1'b1);
        issue(2'b10, 3'b111, 1'b1, 1'b0, 5'h1F, 1'b1, 1'b1);
        // class decode: sub has priority over funct fields
        issue(2'b01, 3'b101, 1'b1, 1'b1, 5'h06, 1'b0, 1'b1);
        issue(2'b11, 3'b010, 1'b0, 1'b1, 5'h06, 1'b0, 1'b1);
        issue(2'b11, 3'b111, 1'b1, 1'b0, 5'h06, 1'b0, 1'b1);
        issue(2'b00, 3'b110, 1'b1, 1'b1, 5'h02, 1'b0, 1'b1);

        // single-cycle latency
        issue(2'b10, 3'b110, 1'b0, 1'b0, 5'h01, 1'b0, 1'b1);
        @(negedge clk);
        chk("single_lat_valid", 32'(out_valid), 1);
        chk("single_lat_sel", 32'(alu_sel), 32'h01);
        @(posedge clk);
        #1;

`ifdef EXU_MULDIV_EN
        // MUL: start pulse, busy for MD_CYC cycles, result after
        issue(2'b10, 3'b000, 1'b0, 1'b1, 5'h10, 1'b0, 1'b1);
        for (int k = 1; k <= int'(MD_CYC) + 1; k++) begin
            @(negedge clk);
            chk("mul_start", 32'(md_start), (k == 1) ? 1 : 0);
            chk("mul_busy", 32'(md_busy), (k <= int'(MD_CYC)) ? 1 : 0);
            chk("mul_valid", 32'(out_valid), (k == int'(MD_CYC) + 1) ? 1 : 0);
            if (k <= int'(MD_CYC)) chk("mul_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        issue(2'b10, 3'b011, 1'b1, 1'b1, 5'h13, 1'b0, 1'b1);
        repeat (int'(MD_CYC) + 2) @(posedge clk);
        #1;
`else
        // MUL without the extension: single-cycle illegal
        issue(2'b10, 3'b000, 1'b0, 1'b1, 5'h1F, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("nomd_busy", 32'(md_busy), 0);
            chk("nomd_start", 32'(md_start), 0);
        end
        @(posedge clk);
        #1;
`endif

        // backpressure on SRA
        out_ready = 1'b0;
        issue(2'b10, 3'b101, 1'b1, 1'b0, 5'h07, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_sel", 32'(alu_sel), 32'h07);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(2'b10, 3'b100, 1'b0, 1'b0, 5'h03, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // op presented alongside flush is dropped
        aluop    = 2'b00;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("flush_drop_valid", 32'(out_valid), 0);
        chk("flush_drop_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

`ifdef EXU_MULDIV_EN
        // flush in RUN cycle 2
        issue(2'b10, 3'b100, 1'b0, 1'b1, 5'h14, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_run_busy_c2", 32'(md_busy), 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_run_busy", 32'(md_busy), 0);
        chk("flush_run_valid", 32'(out_valid), 0);
        chk("flush_run_ready", 32'(in_ready), 1);
        repeat (int'(MD_CYC) + 1) @(negedge clk);
        chk("flush_run_late_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        // async reset mid-RUN
        issue(2'b10, 3'b001, 1'b0, 1'b1, 5'h11, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
`else
        // async reset while holding a stalled result
        out_ready = 1'b0;
        issue(2'b10, 3'b001, 1'b0, 1'b0, 5'h04, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
`endif
        #1;
        chk("arst_busy", 32'(md_busy), 0);
        chk("arst_start", 32'(md_start), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_sel", 32'(alu_sel), 0);
        chk("arst_illegal", 32'(illegal), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rst       = 1'b0;
        repeat (int'(MD_CYC) + 2) @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        issue(2'b10, 3'b011, 1'b0, 1'b0, 5'h09, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exu_ctrl.md
# exu_ctrl

Registered, handshaked ALU-control stage for the execute unit. It replaces the purely combinational ALU-select decode with a parametrised decoder covering the full RV32I register-register op set and optional RV32M mul/div. Decoded selects are held in an output register with valid/ready flow control. For iterative mul/div ops, the block sequences the execution and stalls upstream for a fixed cycle count. It sits between the decode stage (upstream) and the ALU/iterative mul-div datapath (downstream).

## Interface
- SEL_W, 5: alu_sel width; must be ≥5.
- MD_CYCLES, 32: cycles an iterative mul/div op occupies the datapath; must be ≥1.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  block can accept an op this cycle.
- aluop  in  2  main-control class: 00 add, x1 sub, 10 R-type.
- funct3  in  3  inst[14:12].
- funct7_5  in  1  inst[30].
- funct7_0  in  1  inst[25], M-extension flag.
- out_valid  out  1  registered select valid.
- out_ready  in  1  downstream consumes the select.
- alu_sel  out  SEL_W  decoded ALU operation.
- illegal  out  1  the op in the output register did not decode.
- md_start  out  1  one-cycle pulse that launches the iterative unit.
- md_busy  out  1  iterative op in progress.

## Operation
- aluop decode, with priority in this order:
  - aluop[0]=1 → SUB.
  - aluop=00 → ADD.
  - aluop=10 → R-type decode on {funct7_5, funct3}.
- R-type codes:
  - 0000 ADD=0x02, 1000 SUB=0x06.
  - 0111 AND=0x00, 0110 OR=0x01, 0100 XOR=0x03.
  - 0001 SLL=0x04, 0101 SRL=0x05, 1101 SRA=0x07.
  - 0010 SLT=0x08, 0011 SLTU=0x09.
  - Any other combination → illegal.
- aluop=10 with funct7_0=1 is M-extension: alu_sel={2'b10,funct3} (0x10–0x17), treated as a multi-cycle op.
- Illegal: alu_sel = all ones and illegal=1. Illegal ops take the single-cycle path.
- Upper alu_sel bits above bit 4 are zero for every legal code.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: md_busy=1, in_ready=0.
  - OUT: out_valid=1, in_ready=out_ready.
- FSM transitions:
  - IDLE/OUT accepting a single-cycle op → OUT.
  - IDLE/OUT accepting a multi-cycle op → RUN; counter loads MD_CYCLES-1.
  - RUN with counter==0 → OUT; otherwise the counter decrements.
  - OUT with out_ready and no new accept → IDLE.
- Accept = in_valid && in_ready && !flush.
- alu_sel and illegal load only on accept. They stay stable while out_valid && !out_ready.
- flush (any state): next state IDLE, out_valid, md_busy and md_start drop next cycle, counter clears. An op presented in the same cycle is dropped.
- Reset values: state IDLE, alu_sel=0, illegal=0, out_valid=0, md_start=0, md_busy=0, counter=0. Reset during RUN aborts the op with no output.

## Timing
- Single-cycle op accepted at edge N → out_valid high from cycle N+1.
- Back-to-back single-cycle ops: one per cycle while out_ready=1.
- Multi-cycle op accepted at edge N:
  - md_start and md_busy are high in cycle N+1.
  - md_busy stays high for exactly MD_CYCLES cycles.
  - out_valid rises in cycle N+MD_CYCLES+1.
- md_start is high for exactly one cycle per accepted mul/div op.
- Output stall: out_valid && !out_ready holds state. in_ready=0 and no accept occurs.
- All outputs are registered except in_ready, which is combinational from state and out_ready.

## Configuration
- EXU_MULDIV_EN defined: M-extension decode, the RUN state, the counter, md_start and md_busy are present.
- EXU_MULDIV_EN undefined:
  - funct7_0=1 R-type ops decode as illegal on the single-cycle path.
  - md_start and md_busy are tied 0.
  - The FSM has only IDLE and OUT.

## Structure
- Package exu_pkg holds:
  - the ALU_* select constants (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MD base, ILLEGAL);
  - the aluop class constants;
  - the FSM state encoding.
- Sub-module exu_decode: purely combinational {aluop, funct3, funct7_5, funct7_0} → {alu_sel, illegal, is_md}. It is instantiated once by exu_ctrl, and its M-decode is gated by the same macro.

## Test plan
- Decode sweep: aluop=10 with each legal {funct7_5,funct3}, out_ready=1 → alu_sel matches the code list one cycle after accept. 1010 → 0x1F, illegal=1.
- aluop=01 and aluop=11 with random funct fields → alu_sel=0x06. aluop=00 → 0x02.
- MUL (aluop=10, funct7_0=1, funct3=000), MD_CYCLES=4:
  - md_start is high only in cycle N+1;
  - md_busy is high for 4 cycles;
  - out_valid with alu_sel=0x10 in cycle N+5;
  - in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 3 cycles after a SRA → alu_sel=0x07 is held and in_ready=0. A new op is accepted in the cycle out_ready rises.
- flush during RUN (cycle 2 of 4) → IDLE next cycle, md_busy=0, no out_valid. Async rst mid-RUN → all outputs 0 immediately.
- Build without EXU_MULDIV_EN: MUL op → single-cycle illegal=1, alu_sel=0x1F, md_busy never asserts.
